pipe_ctrl_unit: RTL and testbench

- Stall- and flush-aware control unit for the 3-stage (IF / EX / WB) RV32I core.
- Decodes the EX-stage instruction and registers the WB control word.
- Generates WB→EX forwarding selects and squashes the fetched instruction on taken control transfers.
- Sequences variable-latency data-memory accesses through a wait FSM with timeout.

---
 rtl/ctrl_pkg.sv | 102 ++++++++++
 rtl/instr_decode.sv | 130 +++++++++++++
 rtl/pipe_ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the IF/EX/WB pipeline control unit.
// Holds the RV32I opcode constants, the decode enums, the decoded control
// word struct and the ALU function map shared by R-type and I-type decode.
package ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSll  = 4'b0010,
    AluSlt  = 4'b0011,
    AluSltu = 4'b0100,
    AluXor  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluOr   = 4'b1000,
    AluAnd  = 4'b1001,
    AluLui  = 4'b1010
  } aluop_t;

  // Encoded as the branch func3 so the comparator can share the field.
  typedef enum logic [2:0] {
    BrEq  = 3'b000,
    BrNe  = 3'b001,
    BrLt  = 3'b100,
    BrGe  = 3'b101,
    BrLtu = 3'b110,
    BrGeu = 3'b111
  } br_type_t;

  typedef enum logic [2:0] {
    MemB  = 3'b000,
    MemH  = 3'b001,
    MemW  = 3'b010,
    MemBu = 3'b011,
    MemHu = 3'b100
  } mem_type_t;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmJ = 3'b001,
    ImmU = 3'b010,
    ImmB = 3'b011,
    ImmS = 3'b100
  } imm_type_t;

  typedef enum logic [1:0] {
    WbAlu  = 2'b00,
    WbMem  = 2'b01,
    WbPc4  = 2'b10,
    WbNone = 2'b11
  } sel_wb_t;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_t;

  typedef struct packed {
    aluop_t    aluop;
    br_type_t  br_type;
    mem_type_t mem_type;
    imm_type_t imm_type;
    logic      sel_opr_a;
    logic      sel_opr_b;
    logic      is_branch;
    logic      is_jump;
    logic      rd_en;
    logic      wr_en;
    logic      rf_en;
    sel_wb_t   sel_wb;
    logic      use_rs2;   // rs2 is a real operand (R/S/B)
    logic      illegal;
  } ctrl_word_t;

  // R and I share one map; only R-type may select SUB, both may select SRA.
  function automatic aluop_t alu_map(input logic [2:0] func3, input logic alt,
                                     input logic is_r);
    aluop_t op;
    case (func3)
      3'b000:  op = (alt && is_r) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32I decoder for the EX-stage instruction.
// Ports:
//   instr     in   32-bit instruction from the IF/EX register
//   instr_vld in   instruction is real; 0 yields an all-zero control word
//   cw        out  decoded control word
// Undecodable instructions produce a bubble with only the illegal bit set.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        instr_vld,
  output ctrl_word_t  cw
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       alt;
  logic       bad;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign func3       = instr[14:12];
  assign alt         = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    cw  = '0;
    bad = 1'b0;
    if (instr_vld) begin
      case (opcode)
        OpcR: begin
          cw.aluop   = alu_map(func3, alt, 1'b1);
          cw.rf_en   = 1'b1;
          cw.sel_wb  = WbAlu;
          cw.use_rs2 = 1'b1;
        end
        OpcI: begin
          cw.aluop     = alu_map(func3, alt, 1'b0);
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmI;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbAlu;
        end
        OpcLoad: begin
          cw.aluop     = AluAdd;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmI;
          cw.rd_en     = 1'b1;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbMem;
          case (func3)
            3'b000:  cw.mem_type = MemB;
            3'b001:  cw.mem_type = MemH;
            3'b010:  cw.mem_type = MemW;
            3'b100:  cw.mem_type = MemBu;
            3'b101:  cw.mem_type = MemHu;
            default: bad = 1'b1;
          endcase
        end
        OpcStore: begin
          cw.aluop     = AluAdd;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmS;
          cw.wr_en     = 1'b1;
          cw.sel_wb    = WbNone;
          cw.use_rs2   = 1'b1;
          case (func3)
            3'b000:  cw.mem_type = MemB;
            3'b001:  cw.mem_type = MemH;
            3'b010:  cw.mem_type = MemW;
            default: bad = 1'b1;
          endcase
        end
        OpcBranch: begin
          // ALU computes the target PC + imm; rs1/rs2 go to the comparator.
          cw.aluop     = AluAdd;
          cw.sel_opr_a = 1'b1;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmB;
          cw.is_branch = 1'b1;
          cw.sel_wb    = WbNone;
          cw.use_rs2   = 1'b1;
          if (func3 == 3'b010 || func3 == 3'b011) begin
            bad = 1'b1;
          end else begin
            cw.br_type = br_type_t'(func3);
          end
        end
        OpcJal: begin
          cw.aluop     = AluAdd;
          cw.sel_opr_a = 1'b1;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmJ;
          cw.is_jump   = 1'b1;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbPc4;
        end
        OpcJalr: begin
          cw.aluop     = AluAdd;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmI;
          cw.is_jump   = 1'b1;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbPc4;
        end
        OpcLui: begin
          cw.aluop     = AluLui;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmU;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbAlu;
        end
        OpcAuipc: begin
          cw.aluop     = AluAdd;
          cw.sel_opr_a = 1'b1;
          cw.sel_opr_b = 1'b1;
          cw.imm_type  = ImmU;
          cw.rf_en     = 1'b1;
          cw.sel_wb    = WbAlu;
        end
        default: bad = 1'b1;
      endcase
      if (bad) begin
        cw         = '0;
        cw.illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Stall- and flush-aware control unit for the 3-stage IF/EX/WB RV32I core.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr, instr_vld      IF/EX instruction and its valid bit
//   br_taken              branch comparator result for the EX instruction
//   dmem_ready            data memory finished the current access
//   aluop..sel_opr_b      combinational decode of the EX instruction
//   sel_pc, flush         PC redirect and IF/EX squash
//   rd_en, wr_en, stall   data-memory requests and pipeline hold
//   fwd_a, fwd_b          WB->EX forwarding selects
//   rf_en_wb, sel_wb_wb,  registered WB control word
//   rd_wb
//   illegal, bus_err      sticky error flags
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned EN_FWD  = 1,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_vld,
  input  logic             br_taken,
  input  logic             dmem_ready,
  output logic [3:0]       aluop,
  output logic [2:0]       br_type,
  output logic [2:0]       mem_type,
  output logic [2:0]       imm_type,
  output logic             sel_opr_a,
  output logic             sel_opr_b,
  output logic             sel_pc,
  output logic             rd_en,
  output logic             wr_en,
  output logic             stall,
  output logic             flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             rf_en_wb,
  output logic [1:0]       sel_wb_wb,
  output logic [RF_AW-1:0] rd_wb,
  output logic             illegal,
  output logic             bus_err
);

  // Last wait cycle in which dmem_ready is still accepted.
  localparam logic [7:0] TmoLast = 8'(MEM_TMO - 1);

  ctrl_word_t       cw;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q;
  logic             rf_en_q;
  sel_wb_t          sel_wb_q;
  logic [RF_AW-1:0] rd_q;
  logic             req_ok;
  logic             wb_bubble;
  logic [RF_AW-1:0] rd, rs1, rs2;

  assign rd  = instr[7 +: RF_AW];
  assign rs1 = instr[15 +: RF_AW];
  assign rs2 = instr[20 +: RF_AW];

  instr_decode u_decode (
    .instr     (instr),
    .instr_vld (instr_vld),
    .cw        (cw)
  );

  assign aluop     = cw.aluop;
  assign br_type   = cw.br_type;
  assign mem_type  = cw.mem_type;
  assign imm_type  = cw.imm_type;
  assign sel_opr_a = cw.sel_opr_a;
  assign sel_opr_b = cw.sel_opr_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    stall     = 1'b0;
    req_ok    = 1'b0;
    wb_bubble = 1'b0;
    case (state_q)
      StRun: begin
        if (cw.rd_en || cw.wr_en) begin
          req_ok = 1'b1;
          if (!dmem_ready) begin
            stall   = 1'b1;
            state_d = StMemWait;
            cnt_d   = 8'd0;
          end
        end
      end
      StMemWait: begin
        // IF/EX is frozen, so cw still describes the outstanding access.
        req_ok = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (dmem_ready) begin
          state_d = StRun;
        end else if (cnt_q == TmoLast) begin
          // Abandon the access: release the pipeline and write nothing back.
          bus_err_d = 1'b1;
          wb_bubble = 1'b1;
          state_d   = StRun;
          cnt_d     = 8'd0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    // Reset kills any outstanding request in the same cycle it is asserted.
    if (rst) begin
      stall  = 1'b0;
      req_ok = 1'b0;
    end
  end

  assign rd_en  = req_ok & cw.rd_en;
  assign wr_en  = req_ok & cw.wr_en;
  assign sel_pc = ~rst & (cw.is_jump | (cw.is_branch & br_taken));
  assign flush  = sel_pc & (state_q == StRun) & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
      rf_en_q   <= 1'b0;
      sel_wb_q  <= WbAlu;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_q | cw.illegal;
      if (stall || wb_bubble) begin
        rf_en_q  <= 1'b0;
        sel_wb_q <= WbAlu;
        rd_q     <= '0;
      end else begin
        rf_en_q  <= cw.rf_en & (rd != '0);
        sel_wb_q <= cw.sel_wb;
        rd_q     <= rd;
      end
    end
  end

  assign rf_en_wb  = rf_en_q;
  assign sel_wb_wb = sel_wb_q;
  assign rd_wb     = rd_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

  assign fwd_a = (EN_FWD != 0) & rf_en_q & (rd_q == rs1) & ~cw.sel_opr_a;
  assign fwd_b = (EN_FWD != 0) & rf_en_q & (rd_q == rs2) & cw.use_rs2;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit. A second instance built
// with forwarding disabled shares the stimulus.
module tb_pipe_ctrl_unit;

  localparam int unsigned RF_AW = 5;

  localparam logic [31:0] I_ADD0  = 32'h0000_0033;  // add x0,x0,x0
  localparam logic [31:0] I_NOP   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;  // sub x3,x1,x2
  localparam logic [31:0] I_ADD   = 32'h0031_8233;  // add x4,x3,x3
  localparam logic [31:0] I_ADDI  = 32'h0042_0293;  // addi x5,x4,4
  localparam logic [31:0] I_SRAI  = 32'h4032_D313;  // srai x6,x5,3
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;  // beq x1,x2,8
  localparam logic [31:0] I_JAL   = 32'h0000_00EF;  // jal x1,0
  localparam logic [31:0] I_LW    = 32'h0000_A283;  // lw x5,0(x1)
  localparam logic [31:0] I_SW    = 32'h0050_A023;  // sw x5,0(x1)
  localparam logic [31:0] I_BADOP = 32'h0000_007F;
  localparam logic [31:0] I_BADLD = 32'h0000_B283;  // load, func3 = 011

  logic clk = 1'b0;
  logic rst, instr_vld, br_taken, dmem_ready;
  logic [31:0] instr;

  logic [3:0] aluop;
  logic [2:0] br_type, mem_type, imm_type;
  logic sel_opr_a, sel_opr_b, sel_pc, rd_en, wr_en, stall, flush, fwd_a, fwd_b;
  logic rf_en_wb, illegal, bus_err;
  logic [1:0] sel_wb_wb;
  logic [RF_AW-1:0] rd_wb;

  logic [3:0] nf_aluop;
  logic [2:0] nf_br_type, nf_mem_type, nf_imm_type;
  logic nf_sel_opr_a, nf_sel_opr_b, nf_sel_pc, nf_rd_en, nf_wr_en, nf_stall, nf_flush;
  logic nf_fwd_a, nf_fwd_b, nf_rf_en_wb, nf_illegal, nf_bus_err;
  logic [1:0] nf_sel_wb_wb;
  logic [RF_AW-1:0] nf_rd_wb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.RF_AW(RF_AW), .EN_FWD(1), .MEM_TMO(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_vld(instr_vld), .br_taken(br_taken),
    .dmem_ready(dmem_ready), .aluop(aluop), .br_type(br_type), .mem_type(mem_type),
    .imm_type(imm_type), .sel_opr_a(sel_opr_a), .sel_opr_b(sel_opr_b), .sel_pc(sel_pc),
    .rd_en(rd_en), .wr_en(wr_en), .stall(stall), .flush(flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .rf_en_wb(rf_en_wb), .sel_wb_wb(sel_wb_wb), .rd_wb(rd_wb),
    .illegal(illegal), .bus_err(bus_err)
  );

  pipe_ctrl_unit #(.RF_AW(RF_AW), .EN_FWD(0), .MEM_TMO(15)) dut_nf (
    .clk(clk), .rst(rst), .instr(instr), .instr_vld(instr_vld), .br_taken(br_taken),
    .dmem_ready(dmem_ready), .aluop(nf_aluop), .br_type(nf_br_type),
    .mem_type(nf_mem_type), .imm_type(nf_imm_type), .sel_opr_a(nf_sel_opr_a),
    .sel_opr_b(nf_sel_opr_b), .sel_pc(nf_sel_pc), .rd_en(nf_rd_en), .wr_en(nf_wr_en),
    .stall(nf_stall), .flush(nf_flush), .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b),
    .rf_en_wb(nf_rf_en_wb), .sel_wb_wb(nf_sel_wb_wb), .rd_wb(nf_rd_wb),
    .illegal(nf_illegal), .bus_err(nf_bus_err)
  );

  // Advance one cycle and land 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] dec;
    rst = 1'b1; instr = I_ADD0; instr_vld = 1'b1; br_taken = 1'b0; dmem_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({rf_en_wb, sel_wb_wb, rd_wb, illegal, bus_err} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_regs got=%b want=0", {rf_en_wb, sel_wb_wb, rd_wb, illegal, bus_err});
    end
    rst = 1'b0;
    #1;
    dec = {aluop, br_type, mem_type, imm_type, sel_opr_a, sel_opr_b, sel_pc, rd_en, wr_en,
           stall, flush, fwd_a, fwd_b};
    n_cmp++;
    if (dec !== 21'b0) begin
      n_bad++; $display("FAIL add_x0_decode got=%b want=0", dec);
    end
    tick();
    n_cmp++;
    if (rf_en_wb !== 1'b0) begin
      n_bad++; $display("FAIL add_x0_rf_en_wb got=%b want=0", rf_en_wb);
    end
  endtask

  task automatic test_alu_fwd();
    instr = I_SUB; #1;
    n_cmp++;
    if (aluop !== 4'b0001) begin
      n_bad++; $display("FAIL sub_aluop got=%b want=0001", aluop);
    end
    tick();
    n_cmp++;
    if ({rf_en_wb, rd_wb, sel_wb_wb} !== {1'b1, 5'd3, 2'b00}) begin
      n_bad++; $display("FAIL sub_wb got=%b/%0d/%b want=1/3/00", rf_en_wb, rd_wb, sel_wb_wb);
    end
    instr = I_ADD; #1;
    n_cmp++;
    if ({aluop, fwd_a, fwd_b} !== {4'b0000, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL add_fwd got=%b/%b%b want=0000/11", aluop, fwd_a, fwd_b);
    end
    n_cmp++;
    if ({nf_fwd_a, nf_fwd_b} !== 2'b00) begin
      n_bad++; $display("FAIL nofwd got=%b%b want=00", nf_fwd_a, nf_fwd_b);
    end
    tick();
    // I-type: imm bits alias rs2 = 4 but must not forward to B.
    instr = I_ADDI; #1;
    n_cmp++;
    if ({aluop, sel_opr_b, fwd_a, fwd_b} !== {4'b0000, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL addi_fwd got=%b/%b/%b%b want=0000/1/10", aluop, sel_opr_b, fwd_a, fwd_b);
    end
    tick();
    instr = I_SRAI; #1;
    n_cmp++;
    if (aluop !== 4'b0111) begin
      n_bad++; $display("FAIL srai_aluop got=%b want=0111", aluop);
    end
    tick();
  endtask

  task automatic test_branch();
    instr = I_BEQ; br_taken = 1'b1; #1;
    n_cmp++;
    if ({sel_pc, flush, imm_type, br_type} !== {1'b1, 1'b1, 3'b011, 3'b000}) begin
      n_bad++;
      $display("FAIL beq_taken got=%b%b/%b/%b want=11/011/000", sel_pc, flush, imm_type, br_type);
    end
    br_taken = 1'b0; #1;
    n_cmp++;
    if ({sel_pc, flush} !== 2'b00) begin
      n_bad++; $display("FAIL beq_not_taken got=%b%b want=00", sel_pc, flush);
    end
    tick();
  endtask

  task automatic test_bubble();
    instr = I_JAL; instr_vld = 1'b1; #1;
    n_cmp++;
    if (sel_pc !== 1'b1) begin
      n_bad++; $display("FAIL jal_sel_pc got=%b want=1", sel_pc);
    end
    instr_vld = 1'b0; #1;
    n_cmp++;
    if ({sel_pc, flush, rd_en, wr_en} !== 4'b0) begin
      n_bad++; $display("FAIL bubble_enables got=%b want=0000", {sel_pc, flush, rd_en, wr_en});
    end
    tick();
    n_cmp++;
    if (rf_en_wb !== 1'b0) begin
      n_bad++; $display("FAIL bubble_rf_en_wb got=%b want=0", rf_en_wb);
    end
    instr_vld = 1'b1;
    tick();
    n_cmp++;
    if ({rf_en_wb, sel_wb_wb, rd_wb} !== {1'b1, 2'b10, 5'd1}) begin
      n_bad++; $display("FAIL jal_wb got=%b/%b/%0d want=1/10/1", rf_en_wb, sel_wb_wb, rd_wb);
    end
    instr = I_NOP;
    tick();
  endtask

  task automatic test_load_wait();
    int stall_cyc = 0;
    int rd_cyc = 0;
    instr = I_LW;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      if (stall === 1'b1) stall_cyc++;
      if (rd_en === 1'b1) rd_cyc++;
      if (i == 0) begin
        n_cmp++;
        if (mem_type !== 3'b010) begin
          n_bad++; $display("FAIL lw_mem_type got=%b want=010", mem_type);
        end
      end
      tick();
      if (i < 3) begin
        n_cmp++;
        if (rf_en_wb !== 1'b0) begin
          n_bad++; $display("FAIL lw_wait_wb cycle=%0d got=%b want=0", i, rf_en_wb);
        end
      end
    end
    n_cmp++;
    if (stall_cyc != 3 || rd_cyc != 4) begin
      n_bad++; $display("FAIL lw_cycles got=stall %0d rd %0d want=stall 3 rd 4", stall_cyc, rd_cyc);
    end
    n_cmp++;
    if ({rf_en_wb, sel_wb_wb, rd_wb} !== {1'b1, 2'b01, 5'd5}) begin
      n_bad++; $display("FAIL lw_wb got=%b/%b/%0d want=1/01/5", rf_en_wb, sel_wb_wb, rd_wb);
    end
    instr = I_NOP; dmem_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_timeout();
    instr = I_SW; dmem_ready = 1'b0; #1;
    n_cmp++;
    if ({wr_en, stall} !== 2'b11) begin
      n_bad++; $display("FAIL sw_issue got=%b%b want=11", wr_en, stall);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({wr_en, stall, bus_err} !== {1'b1, (i < 3), 1'b0}) begin
        n_bad++;
        $display("FAIL sw_wait cycle=%0d got=%b%b%b want=1%b0", i, wr_en, stall, bus_err, (i < 3));
      end
      tick();
    end
    n_cmp++;
    if ({bus_err, rf_en_wb} !== 2'b10) begin
      n_bad++; $display("FAIL sw_timeout got=%b%b want=10", bus_err, rf_en_wb);
    end
    instr = I_NOP; #1;
    n_cmp++;
    if ({wr_en, stall} !== 2'b00) begin
      n_bad++; $display("FAIL sw_after_tmo got=%b%b want=00", wr_en, stall);
    end
    tick();
    n_cmp++;
    if (bus_err !== 1'b1) begin
      n_bad++; $display("FAIL bus_err_sticky got=%b want=1", bus_err);
    end
  endtask

  task automatic test_rst_in_wait();
    instr = I_SW; dmem_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait_pre got=%b want=1", stall);
    end
    rst = 1'b1; #1;
    n_cmp++;
    if ({stall, wr_en} !== 2'b00) begin
      n_bad++; $display("FAIL rst_wait_now got=%b%b want=00", stall, wr_en);
    end
    tick();
    rst = 1'b0; instr = I_NOP; #1;
    n_cmp++;
    if ({stall, wr_en, bus_err} !== 3'b000) begin
      n_bad++; $display("FAIL rst_wait_after got=%b%b%b want=000", stall, wr_en, bus_err);
    end
    tick();
  endtask

  task automatic test_illegal();
    instr = I_BADOP; instr_vld = 1'b1; #1;
    n_cmp++;
    if ({rd_en, wr_en, sel_pc} !== 3'b000) begin
      n_bad++; $display("FAIL badop_enables got=%b want=000", {rd_en, wr_en, sel_pc});
    end
    tick();
    n_cmp++;
    if ({illegal, rf_en_wb} !== 2'b10) begin
      n_bad++; $display("FAIL badop_flag got=%b%b want=10", illegal, rf_en_wb);
    end
    instr = I_NOP;
    tick();
    n_cmp++;
    if (illegal !== 1'b1) begin
      n_bad++; $display("FAIL illegal_sticky got=%b want=1", illegal);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; instr = I_BADOP; instr_vld = 1'b0;
    tick();
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_bad++; $display("FAIL badop_novld got=%b want=0", illegal);
    end
    instr = I_BADLD; instr_vld = 1'b1; #1;
    n_cmp++;
    if ({rd_en, stall} !== 2'b00) begin
      n_bad++; $display("FAIL badld_req got=%b%b want=00", rd_en, stall);
    end
    tick();
    n_cmp++;
    if (illegal !== 1'b1) begin
      n_bad++; $display("FAIL badld_flag got=%b want=1", illegal);
    end
    instr = I_NOP;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_branch();
    test_bubble();
    test_load_wait();
    test_store_timeout();
    test_rst_in_wait();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
